// File: rtl/flag_ctx_stack.sv
// flag_ctx_stack: interrupt-context stack of ALU flags (and optionally the return PC).
// Ports: CLK/RST (sync, active-high), C_in/Z_in/S_in, pc_in, push, pop, restore_ack,
//   clear_err -> restore_valid, restore_word {0,S,C,Z}, restore_pc, pop_ready, depth,
//   full, empty, overflow, underflow. Define FLAG_CTX_PC_EN to store the return PC.
module flag_ctx_stack #(
  parameter int BITS  = 16,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     C_in,
  input  logic                     Z_in,
  input  logic                     S_in,
  input  logic [BITS-1:0]          pc_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     restore_ack,
  input  logic                     clear_err,
  output logic                     restore_valid,
  output logic [BITS-1:0]          restore_word,
  output logic [BITS-1:0]          restore_pc,
  output logic                     pop_ready,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          st_q, st_d;
  logic [PW-1:0]   sp_q, sp_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            valid_q, valid_d;
  logic [2:0]      flg_q, flg_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic [2:0]      flg_mem [DEPTH];

  logic            pop_acc;
  logic            pop_err;
  logic            push_ok;
  logic            ovf_evt;
  logic [PW-1:0]   sp_dec;
  logic [PW-1:0]   wr_ptr;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;

  assign pop_ready = !valid_q | restore_ack;
  assign pop_acc   = pop & pop_ready & !empty_q;
  assign pop_err   = pop & !pop_acc;
  // An accepted pop frees the top slot first, so a push at full still fits.
  assign push_ok   = push & (!full_q | pop_acc);
  assign ovf_evt   = push & full_q & !pop_acc;
  assign sp_dec    = sp_q - PW'(1);
  // Push with accepted pop overwrites the slot just popped.
  assign wr_ptr    = pop_acc ? sp_dec : sp_q;
  assign wr_idx    = wr_ptr[AW-1:0];
  assign rd_idx    = sp_dec[AW-1:0];

  always_comb begin
    sp_d = sp_q;
    if (pop_acc && !push_ok) begin
      sp_d = sp_dec;
    end else if (push_ok && !pop_acc) begin
      sp_d = sp_q + PW'(1);
    end
    full_d  = (sp_d == PW'(DEPTH));
    empty_d = (sp_d == '0);
  end

  always_comb begin
    st_d  = st_q;
    flg_d = flg_q;
    if (pop_acc) begin
      st_d  = HOLD;
      flg_d = flg_mem[rd_idx];
    end else if (st_q == HOLD && restore_ack) begin
      st_d = IDLE;
    end
    valid_d = (st_d == HOLD);
  end

  // Error events take priority over clear_err.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clear_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (ovf_evt) ovf_d = 1'b1;
    if (pop_err) unf_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q    <= IDLE;
      sp_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      valid_q <= 1'b0;
      flg_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      sp_q    <= sp_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      valid_q <= valid_d;
      flg_q   <= flg_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents survive reset.
  always_ff @(posedge CLK) begin
    if (push_ok) flg_mem[wr_idx] <= {S_in, C_in, Z_in};
  end

`ifdef FLAG_CTX_PC_EN
  logic [BITS-1:0] pc_mem [DEPTH];
  logic [BITS-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (pop_acc) pc_d = pc_mem[rd_idx];
  end

  always_ff @(posedge CLK) begin
    if (RST) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  always_ff @(posedge CLK) begin
    if (push_ok) pc_mem[wr_idx] <= pc_in;
  end

  assign restore_pc = pc_q;
`else
  logic unused_pc;
  assign unused_pc  = ^pc_in;
  assign restore_pc = '0;
`endif

  assign restore_valid = valid_q;
  assign restore_word  = {{(BITS-3){1'b0}}, flg_q};
  assign depth         = sp_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;

endmodule

// File: tb/tb_flag_ctx_stack.sv
// tb_flag_ctx_stack: scoreboard bench for flag_ctx_stack.
// A bench-side stack model predicts restore data, occupancy and error flags.
module tb_flag_ctx_stack;

  localparam int BITS  = 16;
  localparam int DEPTH = 4;

  typedef struct {
    logic [BITS-1:0] w;
    logic [BITS-1:0] pc;
  } entry_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            c_in = 1'b0;
  logic            z_in = 1'b0;
  logic            s_in = 1'b0;
  logic [BITS-1:0] pc_in = '0;
  logic            push = 1'b0;
  logic            pop = 1'b0;
  logic            restore_ack = 1'b0;
  logic            clear_err = 1'b0;
  logic            restore_valid;
  logic [BITS-1:0] restore_word;
  logic [BITS-1:0] restore_pc;
  logic            pop_ready;
  logic [2:0]      depth;
  logic            full;
  logic            empty;
  logic            overflow;
  logic            underflow;

  int cnt  = 0;
  int errs = 0;

  entry_t m_stk [$];
  entry_t exp_q [$];
  bit     m_valid = 0;
  bit     m_ovf = 0;
  bit     m_unf = 0;

  flag_ctx_stack #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst),
    .C_in(c_in), .Z_in(z_in), .S_in(s_in),
    .pc_in(pc_in), .push(push), .pop(pop),
    .restore_ack(restore_ack), .clear_err(clear_err),
    .restore_valid(restore_valid), .restore_word(restore_word),
    .restore_pc(restore_pc), .pop_ready(pop_ready),
    .depth(depth), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded, required finish");
    $fatal(1);
  end

  function automatic entry_t mk(input logic [2:0] f, input logic [BITS-1:0] p);
    entry_t e;
    e.w = {{(BITS-3){1'b0}}, f};
`ifdef FLAG_CTX_PC_EN
    e.pc = p;
`else
    e.pc = '0;
`endif
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_rst;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_stk.delete();
    exp_q.delete();
    m_valid = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  // Model: pop first, then push.
  task automatic drive(input bit do_push, input bit do_pop,
                       input logic [2:0] f, input logic [BITS-1:0] p,
                       input logic ack, output bit acc);
    bit ready;
    ready = !m_valid || ack;
    acc = 0;
    if (do_pop) begin
      if (ready && m_stk.size() > 0) begin
        exp_q.push_back(m_stk.pop_back());
        m_valid = 1;
        acc = 1;
      end else begin
        m_unf = 1;
      end
    end
    if (!acc && ack) m_valid = 0;
    if (do_push) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(mk(f, p));
      else m_ovf = 1;
    end
    {s_in, c_in, z_in} = f;
    pc_in = p;
    push = do_push;
    pop = do_pop;
    restore_ack = ack;
    tick();
    push = 1'b0;
    pop = 1'b0;
    restore_ack = 1'b0;
  endtask

  task automatic test_reset;
    apply_rst();
    cnt++; if (depth !== 3'd0) begin errs++; $display("FAIL rst_depth: got %0d want 0", depth); end
    cnt++; if (empty !== 1'b1) begin errs++; $display("FAIL rst_empty: got %b want 1", empty); end
    cnt++; if (full !== 1'b0) begin errs++; $display("FAIL rst_full: got %b want 0", full); end
    cnt++; if (restore_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", restore_valid); end
    cnt++; if (restore_word !== 16'h0) begin errs++; $display("FAIL rst_word: got %h want 0", restore_word); end
    cnt++; if (restore_pc !== 16'h0) begin errs++; $display("FAIL rst_pc: got %h want 0", restore_pc); end
    cnt++; if ({overflow, underflow} !== 2'b00) begin errs++; $display("FAIL rst_err: got %b want 00", {overflow, underflow}); end
    cnt++; if (pop_ready !== 1'b1) begin errs++; $display("FAIL rst_pop_ready: got %b want 1", pop_ready); end
  endtask

  task automatic test_round_trip;
    bit acc;
    entry_t e;
    apply_rst();
    drive(1, 0, 3'b101, 16'h1234, 0, acc);
    cnt++; if (depth !== 3'd1) begin errs++; $display("FAIL rt_push_depth: got %0d want 1", depth); end
    drive(0, 1, 3'b000, 16'h0, 0, acc);
    e = exp_q.pop_front();
    for (int i = 0; i < 4; i++) begin
      cnt++; if (restore_valid !== 1'b1) begin errs++; $display("FAIL rt_valid[%0d]: got %b want 1", i, restore_valid); end
      cnt++; if (restore_word !== e.w) begin errs++; $display("FAIL rt_word[%0d]: got %h want %h", i, restore_word, e.w); end
      cnt++; if (restore_pc !== e.pc) begin errs++; $display("FAIL rt_pc[%0d]: got %h want %h", i, restore_pc, e.pc); end
      if (i < 3) tick();
    end
    cnt++; if (pop_ready !== 1'b0) begin errs++; $display("FAIL rt_ready_hold: got %b want 0", pop_ready); end
    drive(0, 0, 3'b000, 16'h0, 1, acc);
    cnt++; if (restore_valid !== 1'b0) begin errs++; $display("FAIL rt_ack_drop: got %b want 0", restore_valid); end
    cnt++; if (depth !== 3'd0) begin errs++; $display("FAIL rt_depth: got %0d want 0", depth); end
  endtask

  task automatic test_overflow_lifo;
    bit acc;
    entry_t e;
    logic [2:0] pat [5] = '{3'h1, 3'h2, 3'h4, 3'h7, 3'h3};
    apply_rst();
    for (int i = 0; i < 5; i++) drive(1, 0, pat[i], 16'h100 + 16'(i), 0, acc);
    cnt++; if (full !== 1'b1) begin errs++; $display("FAIL ov_full: got %b want 1", full); end
    cnt++; if (depth !== 3'(m_stk.size())) begin errs++; $display("FAIL ov_depth: got %0d want %0d", depth, m_stk.size()); end
    cnt++; if (overflow !== m_ovf) begin errs++; $display("FAIL ov_flag: got %b want %b", overflow, m_ovf); end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 3'b000, 16'h0, 1, acc);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cnt++; if (restore_word !== e.w) begin errs++; $display("FAIL lifo_word[%0d]: got %h want %h", i, restore_word, e.w); end
        cnt++; if (restore_pc !== e.pc) begin errs++; $display("FAIL lifo_pc[%0d]: got %h want %h", i, restore_pc, e.pc); end
      end
      cnt++; if (restore_valid !== 1'b1) begin errs++; $display("FAIL lifo_valid[%0d]: got %b want 1", i, restore_valid); end
    end
    cnt++; if (empty !== 1'b1) begin errs++; $display("FAIL lifo_empty: got %b want 1", empty); end
    cnt++; if (underflow !== m_unf) begin errs++; $display("FAIL lifo_unf: got %b want %b", underflow, m_unf); end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    m_ovf = 0;
    cnt++; if (overflow !== m_ovf) begin errs++; $display("FAIL ov_clear: got %b want %b", overflow, m_ovf); end
  endtask

  task automatic test_underflow;
    bit acc;
    apply_rst();
    drive(0, 1, 3'b000, 16'h0, 0, acc);
    cnt++; if (underflow !== m_unf) begin errs++; $display("FAIL uf_flag: got %b want %b", underflow, m_unf); end
    cnt++; if (restore_valid !== 1'b0) begin errs++; $display("FAIL uf_valid: got %b want 0", restore_valid); end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    m_unf = 0;
    cnt++; if (underflow !== m_unf) begin errs++; $display("FAIL uf_clear: got %b want %b", underflow, m_unf); end
    // Error in the same cycle as clear_err: set wins.
    clear_err = 1'b1;
    drive(0, 1, 3'b000, 16'h0, 0, acc);
    clear_err = 1'b0;
    cnt++; if (underflow !== m_unf) begin errs++; $display("FAIL uf_set_wins: got %b want %b", underflow, m_unf); end
  endtask

  task automatic test_simul;
    bit acc;
    entry_t e;
    apply_rst();
    drive(1, 0, 3'h1, 16'hA001, 0, acc);
    drive(1, 0, 3'h2, 16'hA002, 0, acc);
    drive(1, 1, 3'h6, 16'hA006, 0, acc);
    e = exp_q.pop_front();
    cnt++; if (restore_word !== e.w) begin errs++; $display("FAIL sim_word: got %h want %h", restore_word, e.w); end
    cnt++; if (restore_pc !== e.pc) begin errs++; $display("FAIL sim_pc: got %h want %h", restore_pc, e.pc); end
    cnt++; if (depth !== 3'(m_stk.size())) begin errs++; $display("FAIL sim_depth: got %0d want %0d", depth, m_stk.size()); end
    drive(0, 1, 3'h0, 16'h0, 1, acc);
    e = exp_q.pop_front();
    cnt++; if (restore_word !== e.w) begin errs++; $display("FAIL sim_next: got %h want %h", restore_word, e.w); end
    // Push-with-pop at full: no overflow, depth stays at DEPTH.
    drive(0, 0, 3'h0, 16'h0, 1, acc);
    for (int i = 0; i < 3; i++) drive(1, 0, 3'(i + 3), 16'hB000 + 16'(i), 0, acc);
    cnt++; if (full !== 1'b1) begin errs++; $display("FAIL simf_full: got %b want 1", full); end
    drive(1, 1, 3'h7, 16'hB777, 0, acc);
    e = exp_q.pop_front();
    cnt++; if (overflow !== m_ovf) begin errs++; $display("FAIL simf_ovf: got %b want %b", overflow, m_ovf); end
    cnt++; if (restore_word !== e.w) begin errs++; $display("FAIL simf_word: got %h want %h", restore_word, e.w); end
    cnt++; if (depth !== 3'(m_stk.size())) begin errs++; $display("FAIL simf_depth: got %0d want %0d", depth, m_stk.size()); end
    // Push and pop together while empty: underflow, push still lands.
    apply_rst();
    drive(1, 1, 3'h3, 16'hC003, 0, acc);
    cnt++; if (underflow !== m_unf) begin errs++; $display("FAIL sime_unf: got %b want %b", underflow, m_unf); end
    cnt++; if (depth !== 3'(m_stk.size())) begin errs++; $display("FAIL sime_depth: got %0d want %0d", depth, m_stk.size()); end
    cnt++; if (restore_valid !== 1'b0) begin errs++; $display("FAIL sime_valid: got %b want 0", restore_valid); end
  endtask

  task automatic test_handshake_err;
    bit acc;
    entry_t e;
    apply_rst();
    drive(1, 0, 3'h4, 16'hD004, 0, acc);
    drive(1, 0, 3'h5, 16'hD005, 0, acc);
    drive(0, 1, 3'h0, 16'h0, 0, acc);
    e = exp_q.pop_front();
    cnt++; if (restore_word !== e.w) begin errs++; $display("FAIL hs_word: got %h want %h", restore_word, e.w); end
    cnt++; if (pop_ready !== 1'b0) begin errs++; $display("FAIL hs_ready_lo: got %b want 0", pop_ready); end
    restore_ack = 1'b1;
    #1;
    cnt++; if (pop_ready !== 1'b1) begin errs++; $display("FAIL hs_ready_hi: got %b want 1", pop_ready); end
    restore_ack = 1'b0;
    drive(0, 1, 3'h0, 16'h0, 0, acc);
    cnt++; if (underflow !== m_unf) begin errs++; $display("FAIL hs_unf: got %b want %b", underflow, m_unf); end
    cnt++; if (depth !== 3'(m_stk.size())) begin errs++; $display("FAIL hs_depth: got %0d want %0d", depth, m_stk.size()); end
    cnt++; if (restore_word !== e.w) begin errs++; $display("FAIL hs_hold: got %h want %h", restore_word, e.w); end
    cnt++; if (restore_valid !== 1'b1) begin errs++; $display("FAIL hs_valid: got %b want 1", restore_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_stk.delete();
    exp_q.delete();
    m_valid = 0;
    m_unf = 0;
    cnt++; if (restore_valid !== 1'b0) begin errs++; $display("FAIL hs_rst_valid: got %b want 0", restore_valid); end
    cnt++; if (depth !== 3'd0) begin errs++; $display("FAIL hs_rst_depth: got %0d want 0", depth); end
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_overflow_lifo();
    test_underflow();
    test_simul();
    test_handshake_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, errs);
    $finish;
  end

endmodule
